// File: rtl/csc_dec_hls_deadlock_monitor_gen.sv
// Deadlock monitor for one csc_dec HLS instance: merges local AXIS stall flags with
// qualified child-monitor flags, filters by persistence and keeps sticky debug status.
module csc_dec_hls_deadlock_monitor_gen #(
  parameter int NUM_CUR      = 2,
  parameter int NUM_SUB      = 2,
  parameter int NUM_IDLE     = 3,
  parameter int BLOCK_THRESH = 1,
  parameter int CNT_W        = 8,
  parameter int SRC_W        = ((NUM_CUR + NUM_SUB) > 1) ? $clog2(NUM_CUR + NUM_SUB) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CUR+NUM_SUB-1:0] axis_block_sigs,
  input  logic [NUM_SUB-1:0]         sub_block_sigs,
  input  logic [NUM_IDLE-1:0]        inst_idle_sigs,
  input  logic                       clear,
  output logic                       block,
  output logic                       block_sticky,
  output logic [SRC_W-1:0]           block_src,
  output logic [CNT_W-1:0]           block_cnt
);

  localparam int NUM_SRC = NUM_CUR + NUM_SUB;
  localparam int RUN_W   = ($clog2(BLOCK_THRESH + 1) > 0) ? $clog2(BLOCK_THRESH + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [RUN_W-1:0]     run_reg, run_next;
  logic                 sticky_reg;
  logic [SRC_W-1:0]     src_reg;
  logic [CNT_W-1:0]     cnt_reg;

  logic [NUM_SRC-1:0]   src;
  logic                 raw;
  logic [SRC_W-1:0]     src_idx;
  logic                 enter_blocked;

  // Sub-monitor flags only count while the channel feeding that child is stalled too.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CUR; gi++) begin : g_cur
      assign src[gi] = axis_block_sigs[gi];
    end
    for (gi = 0; gi < NUM_SUB; gi++) begin : g_sub
      assign src[NUM_CUR+gi] = sub_block_sigs[gi] & axis_block_sigs[NUM_CUR+gi];
    end
  endgenerate

  assign raw = (|src) & ~(&inst_idle_sigs);

  always_comb begin
    src_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src[i]) src_idx = SRC_W'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    case (state_reg)
      ST_IDLE: begin
        if (raw && BLOCK_THRESH == 1) begin
          state_next = ST_BLOCKED;
        end else if (raw) begin
          state_next = ST_SUSPECT;
          run_next   = RUN_W'(1);
        end
      end
      ST_SUSPECT: begin
        if (!raw) begin
          state_next = ST_IDLE;
          run_next   = '0;
        end else if (run_reg == RUN_W'(BLOCK_THRESH - 1)) begin
          state_next = ST_BLOCKED;
        end else begin
          run_next = run_reg + RUN_W'(1);
        end
      end
      ST_BLOCKED: begin
        if (!raw) begin
          state_next = ST_IDLE;
          run_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        run_next   = '0;
      end
    endcase
  end

  assign enter_blocked = (state_next == ST_BLOCKED) && (state_reg != ST_BLOCKED);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      run_reg   <= '0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
    end
  end

  // An entry in the same cycle as clear wins, so the new event is not lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sticky_reg <= 1'b0;
      src_reg    <= '0;
      cnt_reg    <= '0;
    end else if (enter_blocked) begin
      sticky_reg <= 1'b1;
      src_reg    <= src_idx;
      if (clear)         cnt_reg <= CNT_W'(1);
      else if (!(&cnt_reg)) cnt_reg <= cnt_reg + CNT_W'(1);
    end else if (clear) begin
      sticky_reg <= 1'b0;
      cnt_reg    <= '0;
    end
  end

  assign block        = (state_reg == ST_BLOCKED);
  assign block_sticky = sticky_reg;
  assign block_src    = src_reg;
  assign block_cnt    = cnt_reg;

endmodule

// File: tb/tb_csc_dec_hls_deadlock_monitor_gen.sv
// Directed bench for the deadlock monitor: a threshold-1 / 2-bit-counter instance and a
// threshold-4 instance share one stimulus stream.
module tb_csc_dec_hls_deadlock_monitor_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] axis_block_sigs = '0;
  logic [1:0] sub_block_sigs = '0;
  logic [2:0] inst_idle_sigs = '0;
  logic       clear = 1'b0;

  logic       blk1, stk1, blk4, stk4;
  logic [1:0] src1, src4;
  logic [1:0] cnt1;
  logic [7:0] cnt4;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  csc_dec_hls_deadlock_monitor_gen #(
    .NUM_CUR(2), .NUM_SUB(2), .NUM_IDLE(3), .BLOCK_THRESH(1), .CNT_W(2)
  ) dut1 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .sub_block_sigs(sub_block_sigs), .inst_idle_sigs(inst_idle_sigs), .clear(clear),
    .block(blk1), .block_sticky(stk1), .block_src(src1), .block_cnt(cnt1)
  );

  csc_dec_hls_deadlock_monitor_gen #(
    .NUM_CUR(2), .NUM_SUB(2), .NUM_IDLE(3), .BLOCK_THRESH(4), .CNT_W(8)
  ) dut4 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .sub_block_sigs(sub_block_sigs), .inst_idle_sigs(inst_idle_sigs), .clear(clear),
    .block(blk4), .block_sticky(stk4), .block_src(src4), .block_cnt(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_blk1", 32'(blk1), 0);
    check("rst_stk1", 32'(stk1), 0);
    check("rst_src1", 32'(src1), 0);
    check("rst_cnt1", 32'(cnt1), 0);
    check("rst_blk4", 32'(blk4), 0);
    check("rst_cnt4", 32'(cnt4), 0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // T1: axis[1] stall
    axis_block_sigs = 4'b0010;
    tick();
    check("t1_blk1", 32'(blk1), 1);
    check("t1_src1", 32'(src1), 1);
    check("t1_cnt1", 32'(cnt1), 1);
    check("t1_stk1", 32'(stk1), 1);
    check("t1_blk4_early", 32'(blk4), 0);
    tick(2);
    check("t1_blk4_3", 32'(blk4), 0);
    tick();
    check("t1_blk4_4", 32'(blk4), 1);
    check("t1_src4", 32'(src4), 1);
    axis_block_sigs = 4'b0000;
    tick();
    check("t1_fall1", 32'(blk1), 0);
    check("t1_fall4", 32'(blk4), 0);
    check("t1_stk_hold", 32'(stk1), 1);

    // T2: threshold filter on dut4
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t2_clr_cnt4", 32'(cnt4), 0);
    check("t2_clr_stk4", 32'(stk4), 0);
    axis_block_sigs = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_p3_blk4", 32'(blk4), 0);
    end
    axis_block_sigs = 4'b0000;
    tick();
    check("t2_gap_blk4", 32'(blk4), 0);
    axis_block_sigs = 4'b0010;
    tick(3);
    check("t2_p4_pre", 32'(blk4), 0);
    tick();
    check("t2_p4_blk4", 32'(blk4), 1);
    check("t2_p4_cnt4", 32'(cnt4), 1);
    axis_block_sigs = 4'b0000;
    tick();
    check("t2_p4_fall", 32'(blk4), 0);

    // T3: sub-monitor qualification
    sub_block_sigs = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_unq_blk1", 32'(blk1), 0);
    end
    check("t3_unq_blk4", 32'(blk4), 0);
    axis_block_sigs = 4'b0100;
    tick();
    check("t3_blk1", 32'(blk1), 1);
    check("t3_src1", 32'(src1), 2);
    tick(3);
    check("t3_blk4", 32'(blk4), 1);
    check("t3_src4", 32'(src4), 2);
    axis_block_sigs = 4'b0101;
    tick();
    check("t3_hold_blk1", 32'(blk1), 1);
    check("t3_hold_src1", 32'(src1), 2);
    check("t3_hold_src4", 32'(src4), 2);
    axis_block_sigs = 4'b0000;
    tick();
    axis_block_sigs = 4'b1010;
    sub_block_sigs = 2'b10;
    tick();
    check("t3_prio_src1", 32'(src1), 1);
    axis_block_sigs = 4'b0000;
    tick();
    axis_block_sigs = 4'b1000;
    tick();
    check("t3_sub1_blk1", 32'(blk1), 1);
    check("t3_sub1_src1", 32'(src1), 3);
    axis_block_sigs = 4'b0000;
    sub_block_sigs = 2'b00;
    tick();

    // T4: all-idle suppression
    axis_block_sigs = 4'b0001;
    inst_idle_sigs = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_idle_blk1", 32'(blk1), 0);
    end
    check("t4_idle_blk4", 32'(blk4), 0);
    inst_idle_sigs = 3'b011;
    tick();
    check("t4_blk1", 32'(blk1), 1);
    check("t4_src1", 32'(src1), 0);
    tick(2);
    check("t4_blk4_pre", 32'(blk4), 0);
    tick();
    check("t4_blk4", 32'(blk4), 1);
    axis_block_sigs = 4'b0000;
    inst_idle_sigs = 3'b000;
    tick();

    // T5: saturation and clear/entry collision on the 2-bit counter
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_clr_cnt1", 32'(cnt1), 0);
    check("t5_clr_stk1", 32'(stk1), 0);
    for (int i = 1; i <= 5; i++) begin
      axis_block_sigs = 4'b0001;
      tick();
      check("t5_cnt1", 32'(cnt1), (i < 3) ? i : 3);
      axis_block_sigs = 4'b0000;
      tick();
    end
    check("t5_sat_blk4", 32'(blk4), 0);
    axis_block_sigs = 4'b0001;
    clear = 1'b1;
    tick();
    check("t5_coll_cnt1", 32'(cnt1), 1);
    check("t5_coll_stk1", 32'(stk1), 1);
    axis_block_sigs = 4'b0000;
    tick();
    check("t5_clr2_cnt1", 32'(cnt1), 0);
    check("t5_clr2_stk1", 32'(stk1), 0);
    clear = 1'b0;
    tick();

    // T6: asynchronous reset while blocked
    axis_block_sigs = 4'b0010;
    tick(4);
    check("t6_pre_blk1", 32'(blk1), 1);
    check("t6_pre_blk4", 32'(blk4), 1);
    reset = 1'b0;
    #1;
    check("t6_async_blk1", 32'(blk1), 0);
    check("t6_async_stk1", 32'(stk1), 0);
    check("t6_async_src1", 32'(src1), 0);
    check("t6_async_cnt1", 32'(cnt1), 0);
    check("t6_async_blk4", 32'(blk4), 0);
    check("t6_async_cnt4", 32'(cnt4), 0);
    #1;
    reset = 1'b1;
    tick();
    check("t6_re_blk1", 32'(blk1), 1);
    check("t6_re_blk4_1", 32'(blk4), 0);
    tick(2);
    check("t6_re_blk4_3", 32'(blk4), 0);
    tick();
    check("t6_re_blk4", 32'(blk4), 1);
    check("t6_re_cnt4", 32'(cnt4), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
